// File: rtl/clkdiv_pkg.sv
// Shared constants for the programmable clock-divider bank.
package clkdiv_pkg;

   localparam int unsigned CLK_FREQ_HZ    = 100_000_000;
   localparam int unsigned NUM_CH_MAX     = 16;
   localparam int unsigned CFG_CH_W       = $clog2(NUM_CH_MAX);
   localparam int unsigned CNT_W_DEF      = 32;
   // Half-period giving a 1 Hz output from the board clock
   localparam int unsigned DEFAULT_HP_DEF = CLK_FREQ_HZ / 2;

endpackage : clkdiv_pkg

// File: rtl/clkdiv_channel.sv
// One divider channel: shadow/active half-period, counter, square-wave output and rise tick.
module clkdiv_channel
   import clkdiv_pkg::*;
#(
   parameter int unsigned CNT_W      = CNT_W_DEF,
   parameter int unsigned DEFAULT_HP = DEFAULT_HP_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sync,
   input  logic             we,
   input  logic [CNT_W-1:0] hp_in,
   output logic             clk_out,
   output logic             tick
);

   logic [CNT_W-1:0] hp_sh_q, hp_sh_d;
   logic [CNT_W-1:0] hp_act_q, hp_act_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_q, out_d;
   logic             tick_q, tick_d;

   // Next-state: disable/sync restart, park on zero half-period, otherwise count to boundary
   always_comb begin
      hp_sh_d  = we ? hp_in : hp_sh_q;
      hp_act_d = hp_act_q;
      cnt_d    = cnt_q;
      out_d    = out_q;
      tick_d   = 1'b0;
      if (!en || sync || (hp_act_q == '0)) begin
         cnt_d    = '0;
         out_d    = 1'b0;
         hp_act_d = hp_sh_q;
      end else if (cnt_q == hp_act_q - CNT_W'(1)) begin
         // Toggle boundary: the only point where a new half-period is adopted
         out_d    = ~out_q;
         tick_d   = ~out_q;
         cnt_d    = '0;
         hp_act_d = hp_sh_q;
      end else begin
         cnt_d    = cnt_q + CNT_W'(1);
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hp_sh_q  <= CNT_W'(DEFAULT_HP);
         hp_act_q <= CNT_W'(DEFAULT_HP);
         cnt_q    <= '0;
         out_q    <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         hp_sh_q  <= hp_sh_d;
         hp_act_q <= hp_act_d;
         cnt_q    <= cnt_d;
         out_q    <= out_d;
         tick_q   <= tick_d;
      end
   end

   assign clk_out = out_q;
   assign tick    = tick_q;

endmodule : clkdiv_channel

// File: rtl/clkdiv_bank.sv
// Bank of independent programmable clock dividers sharing one clock, config port and sync.
module clkdiv_bank
   import clkdiv_pkg::*;
#(
   parameter int unsigned NUM_CH     = 8,
   parameter int unsigned CNT_W      = CNT_W_DEF,
   parameter int unsigned DEFAULT_HP = DEFAULT_HP_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_CH-1:0]   ch_en,
   input  logic                sync,
   input  logic                cfg_we,
   input  logic [CFG_CH_W-1:0] cfg_ch,
   input  logic [CNT_W-1:0]    cfg_hp,
   output logic [NUM_CH-1:0]   clk_out,
   output logic [NUM_CH-1:0]   tick
);

   logic [NUM_CH-1:0] ch_we;

   // One channel per output; writes to channel numbers beyond the bank match no decoder
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign ch_we[i] = cfg_we && (cfg_ch == CFG_CH_W'(i));

      clkdiv_channel #(
         .CNT_W      (CNT_W),
         .DEFAULT_HP (DEFAULT_HP)
      ) u_ch (
         .clk     (clk),
         .rst_n   (rst_n),
         .en      (ch_en[i]),
         .sync    (sync),
         .we      (ch_we[i]),
         .hp_in   (cfg_hp),
         .clk_out (clk_out[i]),
         .tick    (tick[i])
      );
   end

endmodule : clkdiv_bank

// File: tb/tb_clkdiv_bank.sv
// Directed scoreboard bench for clkdiv_bank (4 channels, reset half-period 3).
module tb_clkdiv_bank;

   localparam int unsigned NCH = 4;
   localparam int unsigned CW  = 32;
   localparam int unsigned NE  = 64;

   typedef struct {
      string      tag;
      logic [3:0] out;
      logic [3:0] tck;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [NCH-1:0] ch_en;
   logic           sync;
   logic           cfg_we;
   logic [3:0]     cfg_ch;
   logic [CW-1:0]  cfg_hp;
   logic [NCH-1:0] clk_out;
   logic [NCH-1:0] tick;

   // Per-edge stimulus tables and expected rise/fall edge maps (edge 1 = first edge of a run)
   logic [3:0]     en_tab   [NE];
   logic           we_tab   [NE];
   logic [3:0]     ch_tab   [NE];
   logic [CW-1:0]  hp_tab   [NE];
   logic           sync_tab [NE];
   logic [NE-1:0]  rise_m   [NCH];
   logic [NE-1:0]  fall_m   [NCH];

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   clkdiv_bank #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_HP(3)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ch_en   (ch_en),
      .sync    (sync),
      .cfg_we  (cfg_we),
      .cfg_ch  (cfg_ch),
      .cfg_hp  (cfg_hp),
      .clk_out (clk_out),
      .tick    (tick)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "timeout");
   end

   task automatic clear_tab();
      for (int e = 0; e < NE; e++) begin
         en_tab[e] = '0; we_tab[e] = 1'b0; ch_tab[e] = '0;
         hp_tab[e] = '0; sync_tab[e] = 1'b0;
      end
      for (int c = 0; c < NCH; c++) begin
         rise_m[c] = '0; fall_m[c] = '0;
      end
   endtask

   task automatic set_en(input int from_e, input logic [3:0] val);
      for (int e = from_e; e < NE; e++) en_tab[e] = val;
   endtask

   task automatic wr(input int e, input logic [3:0] ch, input logic [CW-1:0] hp);
      we_tab[e] = 1'b1; ch_tab[e] = ch; hp_tab[e] = hp;
   endtask

   task automatic rise(input int ch, input int e);
      rise_m[ch][e] = 1'b1;
   endtask

   task automatic fall(input int ch, input int e);
      fall_m[ch][e] = 1'b1;
   endtask

   // Output level implied by the most recent rise/fall event at or before edge e
   function automatic logic exp_level(input int ch, input int e);
      for (int k = e; k >= 1; k--) begin
         if (rise_m[ch][k]) return 1'b1;
         if (fall_m[ch][k]) return 1'b0;
      end
      return 1'b0;
   endfunction

   task automatic check_now(input string tag, input logic [3:0] eo, input logic [3:0] et);
      n_tests++;
      assert ({clk_out, tick} === {eo, et}) else begin
         n_fail++;
         $error("FAIL %s: observed out=%b tick=%b expected out=%b tick=%b",
                tag, clk_out, tick, eo, et);
      end
   endtask

   // Drive n edges from the tables, scoreboard the expected outputs, compare after each edge
   task automatic run(input string tag, input int n);
      exp_t x, got;
      for (int e = 1; e <= n; e++) begin
         ch_en  = en_tab[e];
         cfg_we = we_tab[e];
         cfg_ch = ch_tab[e];
         cfg_hp = hp_tab[e];
         sync   = sync_tab[e];
         x.tag  = $sformatf("%s@%0d", tag, e);
         for (int c = 0; c < NCH; c++) begin
            x.out[c] = exp_level(c, e);
            x.tck[c] = rise_m[c][e];
         end
         sb.push_back(x);
         @(posedge clk);
         #1;
         got = sb.pop_front();
         check_now(got.tag, got.out, got.tck);
      end
      cfg_we = 1'b0;
      sync   = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; ch_en = '0; sync = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_hp = '0;
      #12;
      check_now("reset", 4'h0, 4'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset defaults: all channels hp=3 -> rise 3/9/15, fall 6/12, disable at 17 drops high phase
      clear_tab();
      set_en(1, 4'hF);
      set_en(17, 4'h0);
      for (int c = 0; c < NCH; c++) begin
         rise(c, 3); rise(c, 9); rise(c, 15);
         fall(c, 6); fall(c, 12); fall(c, 17);
      end
      run("defaults", 17);

      // Reprogram ch0 to 5 mid-phase: fall at 6 unchanged, then half-periods of 5
      clear_tab();
      set_en(1, 4'b0001);
      wr(4, 4'd0, 5);
      rise(0, 3); fall(0, 6); rise(0, 11); fall(0, 16); rise(0, 21);
      run("reprog", 22);

      // Minimum divide on ch1: clk/2 with tick every other edge
      clear_tab();
      wr(1, 4'd1, 1);
      set_en(3, 4'b0010);
      for (int e = 3; e <= 9; e++) begin
         if (e % 2 == 1) rise(1, e);
         else fall(1, e);
      end
      run("min_div", 9);

      // Park ch2 with hp=0 after its fall at 6, unpark with hp=2 written at 10
      clear_tab();
      set_en(1, 4'b0100);
      wr(4, 4'd2, 0);
      wr(10, 4'd2, 2);
      rise(2, 3); fall(2, 6); rise(2, 13); fall(2, 15); rise(2, 17);
      run("park", 18);

      // Sync: ch0/ch3 hp=4 started two cycles apart, sync at 12 realigns them
      clear_tab();
      wr(1, 4'd0, 4);
      wr(2, 4'd3, 4);
      set_en(4, 4'b0001);
      set_en(6, 4'b1001);
      sync_tab[12] = 1'b1;
      rise(0, 7); fall(0, 11); rise(0, 16); fall(0, 20); rise(0, 24);
      rise(3, 9); fall(3, 12); rise(3, 16); fall(3, 20); rise(3, 24);
      run("sync", 24);

      // Out-of-range write (ch 9) must not disturb any channel's half-period
      clear_tab();
      wr(1, 4'd9, 7);
      set_en(3, 4'hF);
      rise(0, 6);
      rise(1, 3); fall(1, 4); rise(1, 5); fall(1, 6); rise(1, 7);
      rise(2, 4); fall(2, 6);
      rise(3, 6);
      run("oor", 7);

      // Async reset during high phase clears outputs without a clock edge
      #2;
      rst_n = 1'b0;
      #1;
      check_now("async_rst", 4'h0, 4'h0);
      @(posedge clk);
      #1;
      check_now("rst_hold", 4'h0, 4'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Half-periods return to the reset default after reset
      clear_tab();
      set_en(1, 4'hF);
      for (int c = 0; c < NCH; c++) rise(c, 3);
      run("post_rst", 4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_clkdiv_bank

// File: doc/clkdiv_bank.md
# clkdiv_bank

Parametrised bank of independent programmable clock dividers driving the JC Pmod header (and internal logic) from the single board clock. Each channel generates a 50 % duty square wave with a runtime-programmable half-period, plus a one-cycle tick on every rising edge of its output. Reconfiguration is glitch-free: new values take effect only at a toggle boundary. A global sync input phase-aligns all channels.

## Interface
- NUM_CH, 8, number of divider channels (1..16)
- CNT_W, 32, width of half-period and counter
- DEFAULT_HP, 50_000_000, half-period loaded into every channel at reset (1 Hz from 100 MHz)

- clk  in  1  system clock (100 MHz board clock)
- rst_n  in  1  asynchronous, active-low reset
- ch_en  in  NUM_CH  per-channel run enable (level)
- sync  in  1  synchronous restart of all channels (pulse)
- cfg_we  in  1  shadow half-period write strobe
- cfg_ch  in  4  target channel of write
- cfg_hp  in  CNT_W  half-period value, in clk cycles
- clk_out  out  NUM_CH  divided square waves (registered)
- tick  out  NUM_CH  one-cycle pulse, high in the first cycle clk_out[i] is 1

## Operation
- Per channel registers: shadow hp_sh, active hp_act, counter cnt, out, tick.
- Config: cfg_we=1 with cfg_ch < NUM_CH writes hp_sh[cfg_ch] <= cfg_hp; cfg_ch >= NUM_CH ignored. Only hp_sh is written; hp_act never changes directly.
- Per-channel priority at each clk edge: disable > sync > count.
- Disabled (ch_en[i]=0): cnt<=0, out<=0, tick<=0, hp_act<=hp_sh.
- Sync (sync=1, ch_en[i]=1): cnt<=0, out<=0, tick<=0, hp_act<=hp_sh.
- Count, hp_act=0: out<=0, cnt<=0, hp_act<=hp_sh each cycle (channel parked until a nonzero value is written).
- Count, hp_act!=0: if cnt==hp_act-1 then out<=~out, cnt<=0, hp_act<=hp_sh; else cnt<=cnt+1.
- tick<=1 exactly when out transitions 0->1 that edge; else 0.
- Output period = 2*hp_act cycles; hp_act=1 gives clk/2.
- Write to hp_sh in the same cycle as a reload: reload takes the old hp_sh; new value used at the next boundary.
- Counter never exceeds hp_act-1; no wrap-around at CNT_W limit.

## Timing
- Reset (async assert, released synchronously by the board reset logic): out=0, tick=0, cnt=0, hp_sh=hp_act=DEFAULT_HP for all channels.
- With ch_en[i] high from edge 0 onward: out rises at edge hp_act, falls at edge 2*hp_act, repeats.
- cfg write to boundary: new half-period applies from the first toggle after the write edge; half-cycles already in progress complete unchanged (no runt pulses).
- ch_en deassert: out forced low at the next edge (may truncate a high phase; documented, intended).
- Sync: all enabled channels show out=0 after the sync edge and rise together hp_act cycles later if their hp_act are equal.
- All outputs registered; no combinational path input-to-output.

## Structure
- Package clkdiv_pkg: NUM_CH_MAX=16, default CNT_W, DEFAULT_HP, helper constant for 100 MHz clk frequency.
- Sub-module clkdiv_channel (one per channel, generate loop): holds hp_sh/hp_act/cnt/out/tick; top decodes cfg_ch into per-channel write enables and fans out sync.

## Test plan
- Reset defaults: NUM_CH=4, DEFAULT_HP=3, ch_en=4'hF after reset -> all clk_out rise at edge 3, fall at edge 6, tick high at edges 3, 9, 15.
- Reprogram mid-run: ch0 hp=3 running, write cfg_hp=5 at edge 4 -> current low/high phase finishes at edge 6, then half-periods of 5 (toggles at 11, 16).
- Minimum divide: write hp=1 to ch1 -> clk_out[1] toggles every edge (clk/2), tick every 2 cycles.
- Park/unpark: write hp=0 to ch2 -> clk_out[2] stays 0 after current boundary; write hp=2 -> first rise 2 cycles after reload.
- Sync alignment: ch0 hp=4, ch3 hp=4 started 2 cycles apart; pulse sync -> both 0 next edge, both rise together 4 edges later.
- Out-of-range and async reset: cfg_ch=9 with NUM_CH=4 -> no channel changes; assert rst_n=0 mid-high-phase -> clk_out=0, tick=0 immediately without a clock edge.
